// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - TD4 opcode and ALU source select encodings
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/td4_decode.sv
// rtl/td4_decode.sv - combinational opcode decode: ALU source, raw load strobes, jump
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] OP,
  input  logic       CFLAG,
  output logic [1:0] SEL,
  output logic       load_a_n,
  output logic       load_b_n,
  output logic       load_out_n,
  output logic       jump_taken
);

  always_comb begin
    SEL        = SEL_ZERO;
    load_a_n   = 1'b1;
    load_b_n   = 1'b1;
    load_out_n = 1'b1;
    jump_taken = 1'b0;
    unique case (OP)
      OP_ADD_A:  begin SEL = SEL_A;    load_a_n   = 1'b0; end
      OP_MOV_AB: begin SEL = SEL_B;    load_a_n   = 1'b0; end
      OP_IN_A:   begin SEL = SEL_IN;   load_a_n   = 1'b0; end
      OP_MOV_AI: begin SEL = SEL_ZERO; load_a_n   = 1'b0; end
      OP_MOV_BA: begin SEL = SEL_A;    load_b_n   = 1'b0; end
      OP_ADD_B:  begin SEL = SEL_B;    load_b_n   = 1'b0; end
      OP_IN_B:   begin SEL = SEL_IN;   load_b_n   = 1'b0; end
      OP_MOV_BI: begin SEL = SEL_ZERO; load_b_n   = 1'b0; end
      OP_OUT_B:  begin SEL = SEL_B;    load_out_n = 1'b0; end
      OP_OUT_I:  begin SEL = SEL_ZERO; load_out_n = 1'b0; end
      OP_JNC:    begin SEL = SEL_ZERO; jump_taken = ~CFLAG; end
      OP_JMP:    begin SEL = SEL_ZERO; jump_taken = 1'b1; end
      default:   begin SEL = SEL_ZERO; end
    endcase
  end

endmodule

// File: rtl/td4_control.sv
// rtl/td4_control.sv - TD4 control unit: PC, carry flag, halt and gated load strobes
module td4_control
  import td4_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       EN,
  input  logic [3:0] OP,
  input  logic [3:0] IM,
  input  logic       ALU_CARRY,
  output logic [3:0] PC,
  output logic [1:0] SEL,
  output logic       LOAD_A,
  output logic       LOAD_B,
  output logic       LOAD_OUT,
  output logic       CFLAG,
  output logic       HALTED
);

  logic [3:0] pc_q, pc_d;
  logic       cflag_q, cflag_d;
  logic       halted_q, halted_d;
  logic       load_a_n, load_b_n, load_out_n, jump_taken;
  logic       exec;

  td4_decode u_decode (
    .OP         (OP),
    .CFLAG      (cflag_q),
    .SEL        (SEL),
    .load_a_n   (load_a_n),
    .load_b_n   (load_b_n),
    .load_out_n (load_out_n),
    .jump_taken (jump_taken)
  );

  assign exec = EN & ~halted_q;

  always_comb begin
    pc_d     = pc_q;
    cflag_d  = cflag_q;
    halted_d = halted_q;
    if (exec) begin
      pc_d    = jump_taken ? IM : pc_q + 4'd1;
      cflag_d = ALU_CARRY;
      // A JMP onto itself is the program's way of stopping.
      if (OP == OP_JMP && IM == pc_q) halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      pc_q     <= 4'd0;
      cflag_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cflag_q  <= cflag_d;
      halted_q <= halted_d;
    end
  end

  assign LOAD_A   = load_a_n   | ~exec;
  assign LOAD_B   = load_b_n   | ~exec;
  assign LOAD_OUT = load_out_n | ~exec;
  assign PC       = pc_q;
  assign CFLAG    = cflag_q;
  assign HALTED   = halted_q;

endmodule

// File: tb/tb_td4_control.sv
// tb/tb_td4_control.sv - directed self-checking bench for td4_control
module tb_td4_control;

  logic       CLK, RSTB, EN, ALU_CARRY;
  logic [3:0] OP, IM, PC;
  logic [1:0] SEL;
  logic       LOAD_A, LOAD_B, LOAD_OUT, CFLAG, HALTED;

  int checks = 0;
  int errors = 0;

  td4_control dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .EN        (EN),
    .OP        (OP),
    .IM        (IM),
    .ALU_CARRY (ALU_CARRY),
    .PC        (PC),
    .SEL       (SEL),
    .LOAD_A    (LOAD_A),
    .LOAD_B    (LOAD_B),
    .LOAD_OUT  (LOAD_OUT),
    .CFLAG     (CFLAG),
    .HALTED    (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTB = 1'b0; EN = 1'b0; OP = 4'b1000; IM = 4'd0; ALU_CARRY = 1'b0;
    #12;
    checks++;
    if (PC !== 4'd0 || CFLAG !== 1'b0 || HALTED !== 1'b0) begin
      errors++;
      $display("FAIL reset_state actual pc=%0h c=%0b h=%0b required pc=0 c=0 h=0", PC, CFLAG, HALTED);
    end
    checks++;
    if ({LOAD_A, LOAD_B, LOAD_OUT} !== 3'b111) begin
      errors++;
      $display("FAIL reset_loads actual=%b required=111", {LOAD_A, LOAD_B, LOAD_OUT});
    end
    RSTB = 1'b1;
    step();
  endtask

  task automatic test_nop_stream();
    EN = 1'b1; OP = 4'b1000; ALU_CARRY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      OP = (i % 4 == 0) ? 4'b1000 : (i % 4 == 1) ? 4'b1010 : (i % 4 == 2) ? 4'b1100 : 4'b1101;
      #1;
      checks++;
      if (PC !== i[3:0] || CFLAG !== 1'b0 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b111 || SEL !== 2'b11) begin
        errors++;
        $display("FAIL nop_step%0d actual pc=%0h c=%0b loads=%b sel=%b required pc=%0h c=0 loads=111 sel=11",
                 i, PC, CFLAG, {LOAD_A, LOAD_B, LOAD_OUT}, SEL, i[3:0]);
      end
      step();
    end
    checks++;
    if (PC !== 4'd0) begin
      errors++;
      $display("FAIL nop_wrap actual pc=%0h required pc=0", PC);
    end
    OP = 4'b1000;
    repeat (3) step();
  endtask

  task automatic test_add();
    OP = 4'b0000; IM = 4'd5; ALU_CARRY = 1'b1;
    #1;
    checks++;
    if (SEL !== 2'b00 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b011) begin
      errors++;
      $display("FAIL add_decode actual sel=%b loads=%b required sel=00 loads=011", SEL, {LOAD_A, LOAD_B, LOAD_OUT});
    end
    step();
    checks++;
    if (PC !== 4'd4 || CFLAG !== 1'b1) begin
      errors++;
      $display("FAIL add_update actual pc=%0h c=%0b required pc=4 c=1", PC, CFLAG);
    end
  endtask

  task automatic test_decode_table();
    OP = 4'b1001; #1;
    checks++;
    if (SEL !== 2'b01 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b110) begin
      errors++;
      $display("FAIL out_b_decode actual sel=%b loads=%b required sel=01 loads=110", SEL, {LOAD_A, LOAD_B, LOAD_OUT});
    end
    OP = 4'b0110; #1;
    checks++;
    if (SEL !== 2'b10 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b101) begin
      errors++;
      $display("FAIL in_b_decode actual sel=%b loads=%b required sel=10 loads=101", SEL, {LOAD_A, LOAD_B, LOAD_OUT});
    end
    OP = 4'b0001; #1;
    checks++;
    if (SEL !== 2'b01 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b011) begin
      errors++;
      $display("FAIL mov_ab_decode actual sel=%b loads=%b required sel=01 loads=011", SEL, {LOAD_A, LOAD_B, LOAD_OUT});
    end
  endtask

  task automatic test_jnc();
    OP = 4'b1110; IM = 4'd9; ALU_CARRY = 1'b0;
    #1;
    checks++;
    if (SEL !== 2'b11 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b111) begin
      errors++;
      $display("FAIL jnc_decode actual sel=%b loads=%b required sel=11 loads=111", SEL, {LOAD_A, LOAD_B, LOAD_OUT});
    end
    step();
    checks++;
    if (PC !== 4'd5 || CFLAG !== 1'b0) begin
      errors++;
      $display("FAIL jnc_not_taken actual pc=%0h c=%0b required pc=5 c=0", PC, CFLAG);
    end
    step();
    checks++;
    if (PC !== 4'd9) begin
      errors++;
      $display("FAIL jnc_taken actual pc=%0h required pc=9", PC);
    end
    step();
    checks++;
    if (PC !== 4'd9 || HALTED !== 1'b0) begin
      errors++;
      $display("FAIL jnc_self actual pc=%0h h=%0b required pc=9 h=0", PC, HALTED);
    end
    OP = 4'b0011; IM = 4'd2; ALU_CARRY = 1'b1;
    step();
    checks++;
    if (PC !== 4'd10 || CFLAG !== 1'b1) begin
      errors++;
      $display("FAIL mov_ai_update actual pc=%0h c=%0b required pc=a c=1", PC, CFLAG);
    end
  endtask

  task automatic test_en_hold();
    EN = 1'b0; OP = 4'b0100; ALU_CARRY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (LOAD_B !== 1'b1 || SEL !== 2'b00) begin
        errors++;
        $display("FAIL en_hold_strobe%0d actual load_b=%0b sel=%b required load_b=1 sel=00", i, LOAD_B, SEL);
      end
      step();
      checks++;
      if (PC !== 4'd10 || CFLAG !== 1'b1 || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL en_hold_state%0d actual pc=%0h c=%0b h=%0b required pc=a c=1 h=0", i, PC, CFLAG, HALTED);
      end
    end
    EN = 1'b1; ALU_CARRY = 1'b1;
    #1;
    checks++;
    if (LOAD_B !== 1'b0) begin
      errors++;
      $display("FAIL en_resume_strobe actual load_b=%0b required load_b=0", LOAD_B);
    end
    step();
    checks++;
    if (PC !== 4'd11 || CFLAG !== 1'b1) begin
      errors++;
      $display("FAIL en_resume_state actual pc=%0h c=%0b required pc=b c=1", PC, CFLAG);
    end
  endtask

  task automatic test_async_reset();
    EN = 1'b0;
    #2;
    RSTB = 1'b0;
    #1;
    checks++;
    if (PC !== 4'd0 || CFLAG !== 1'b0) begin
      errors++;
      $display("FAIL async_reset actual pc=%0h c=%0b required pc=0 c=0", PC, CFLAG);
    end
    #1;
    RSTB = 1'b1;
    EN = 1'b1; OP = 4'b1000; ALU_CARRY = 1'b0;
    step();
    checks++;
    if (PC !== 4'd1) begin
      errors++;
      $display("FAIL reset_restart actual pc=%0h required pc=1", PC);
    end
  endtask

  task automatic test_halt();
    repeat (5) step();
    OP = 4'b1111; IM = 4'd6; ALU_CARRY = 1'b0;
    #1;
    checks++;
    if (PC !== 4'd6 || {LOAD_A, LOAD_B, LOAD_OUT} !== 3'b111) begin
      errors++;
      $display("FAIL halt_pre actual pc=%0h loads=%b required pc=6 loads=111", PC, {LOAD_A, LOAD_B, LOAD_OUT});
    end
    step();
    checks++;
    if (HALTED !== 1'b1 || PC !== 4'd6) begin
      errors++;
      $display("FAIL halt_set actual h=%0b pc=%0h required h=1 pc=6", HALTED, PC);
    end
    OP = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      ALU_CARRY = ~ALU_CARRY;
      #1;
      checks++;
      if ({LOAD_A, LOAD_B, LOAD_OUT} !== 3'b111) begin
        errors++;
        $display("FAIL halt_strobes%0d actual loads=%b required loads=111", i, {LOAD_A, LOAD_B, LOAD_OUT});
      end
      step();
      checks++;
      if (PC !== 4'd6 || CFLAG !== 1'b0 || HALTED !== 1'b1) begin
        errors++;
        $display("FAIL halt_frozen%0d actual pc=%0h c=%0b h=%0b required pc=6 c=0 h=1", i, PC, CFLAG, HALTED);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_add();
    test_decode_table();
    test_jnc();
    test_en_hold();
    test_async_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_control.md
# td4_control

Control unit for the TD4 4-bit CPU: program counter, carry flag, and instruction decoder. Each executed cycle it takes the current opcode and immediate from program ROM. It then drives the ALU-input select and the active-low `LOAD` strobes of the A, B and OUT `register` instances, and advances or jumps the PC. It is the driving end of the register `LOAD` interface: the registers capture on `LOAD==0` and hold on `LOAD==1`.

## Interface
Parameters:
- none (width fixed at 4 bits by the TD4 ISA)

Ports:
- `CLK` in 1: system clock; all state updates on its rising edge.
- `RSTB` in 1: reset, asynchronous, active-low.
- `EN` in 1: execute enable. 0 freezes all state and deasserts all loads.
- `OP` in 4: opcode field of the instruction at `PC`.
- `IM` in 4: immediate field of the instruction at `PC`.
- `ALU_CARRY` in 1: carry out of the external 4-bit adder (selected source + `IM`).
- `PC` out 4: program ROM address.
- `SEL` out 2: ALU source select. 00=A, 01=B, 10=IN port, 11=zero.
- `LOAD_A`, `LOAD_B`, `LOAD_OUT` out 1 each: active-low capture strobes for the A, B and OUT registers.
- `CFLAG` out 1: carry flag.
- `HALTED` out 1: sticky halt indicator.

## Operation
- Executed cycle: `EN==1` and `HALTED==0`. Otherwise all `LOAD_*` are 1 and `PC`, `CFLAG` and `HALTED` hold.
- Decode is combinational from `OP`, `CFLAG`, `EN` and `HALTED`. Sources and strobes per opcode:
  - 0000 ADD A,Im: SEL=00, LOAD_A=0.
  - 0001 MOV A,B: SEL=01, LOAD_A=0.
  - 0010 IN A: SEL=10, LOAD_A=0.
  - 0011 MOV A,Im: SEL=11, LOAD_A=0.
  - 0100 MOV B,A: SEL=00, LOAD_B=0.
  - 0101 ADD B,Im: SEL=01, LOAD_B=0.
  - 0110 IN B: SEL=10, LOAD_B=0.
  - 0111 MOV B,Im: SEL=11, LOAD_B=0.
  - 1001 OUT B: SEL=01, LOAD_OUT=0.
  - 1011 OUT Im: SEL=11, LOAD_OUT=0.
  - 1110 JNC Im: SEL=11; jump taken iff `CFLAG==0`.
  - 1111 JMP Im: SEL=11; jump always taken.
  - 1000, 1010, 1100, 1101: NOP. SEL=11, no load strobes, PC increments.
- When not executing, `SEL` still decodes `OP` but all strobes stay high.
- At most one `LOAD_*` is low in any cycle.
- PC on an executed cycle:
  - Taken jump: `PC <= IM`.
  - Otherwise: `PC <= PC + 1`, modulo 16 (15 wraps to 0).
- CFLAG on every executed cycle, including NOP, MOV and jumps: `CFLAG <= ALU_CARRY`. JNC tests the flag left by the previous executed instruction.
- HALTED is set on an executed JMP (1111) with `IM == PC`. The PC still loads `IM`, so it is unchanged. HALTED clears only on reset.
- JNC to its own address never sets HALTED.

## Timing
- Reset (`RSTB==0`, asynchronous): `PC=0`, `CFLAG=0`, `HALTED=0`. The `LOAD_*` outputs follow the decode of the current `OP`; the registers are themselves held in reset.
- Reset deasserting mid-program restarts at `PC=0` on the next edge after release.
- Latency:
  - `SEL` and `LOAD_*` are valid combinationally within the cycle that presents `OP`.
  - Register capture, `PC` update and `CFLAG` update all occur at the same rising edge.
  - One instruction per executed cycle; no fetch/execute split.
- `EN` falling: the instruction presented in that cycle does not execute and is re-presented when `EN` returns to 1.
- `EN==1` together with a halting JMP: HALTED rises at that edge; strobes are high from the next cycle onward.

## Structure
- Shared package `td4_pkg`:
  - opcode localparams (`OP_ADD_A` … `OP_JMP`);
  - `SEL` encodings (`SEL_A`, `SEL_B`, `SEL_IN`, `SEL_ZERO`).
- One combinational sub-module, `td4_decode`: inputs `OP`, `CFLAG`; outputs `SEL`, the raw load strobes and `jump_taken`.
- `td4_control` owns `PC`, `CFLAG`, `HALTED` and the `EN`/`HALTED` gating of the strobes.

## Test plan
- Reset then `EN=1`, NOP stream with `ALU_CARRY=0`:
  - PC steps 0,1,…,15,0.
  - All `LOAD_*` stay 1; `CFLAG` stays 0.
- OP=0000, IM=5, ALU_CARRY=1 at PC=3:
  - Within the cycle: SEL=00, LOAD_A=0, LOAD_B=1, LOAD_OUT=1.
  - After the edge: PC=4, CFLAG=1.
- JNC with IM=9, presented twice:
  - After an instruction that set CFLAG=1: not taken, PC increments.
  - After an instruction that left CFLAG=0: taken, PC=9.
- OP=1111, IM=6 at PC=6:
  - After the edge: HALTED=1, PC stays 6.
  - Subsequent cycles: all strobes high; CFLAG frozen despite ALU_CARRY toggling.
- EN=0 for 3 cycles mid-program with OP=0100: PC, CFLAG and HALTED hold; LOAD_B=1 throughout.
- RSTB pulsed low between clock edges while PC=0xB and CFLAG=1: PC=0 and CFLAG=0 immediately, with no clock edge required.
